priority_encoder_reg: RTL and testbench

- Registered, parametrised N-to-log2(N) priority encoder with sticky request capture and a valid/ack handshake.
- Generalises the 8×3 one-hot encoder. Accepts any number of simultaneous requests, selects by fixed or round-robin priority, and holds the result until consumed.
- Sits between interrupt/flag sources and the control sequencer. The sequencer reads out_index as a vector number.

---
 rtl/priority_encoder_reg_pkg.sv | 17 +
 rtl/priority_encoder_reg_pick.sv | 27 ++
 rtl/priority_encoder_reg.sv | 111 +++++++++++
 tb/tb_priority_encoder_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_reg_pkg.sv
// Shared types and helpers for the registered priority encoder.
// Prio mode selects lowest-index-first or rotating priority.
package priority_encoder_reg_pkg;

   typedef enum logic {PRIO_FIXED, PRIO_ROUND_ROBIN} prio_mode_e;

   // Number of index bits needed to address n request lines.
   function automatic int unsigned clog2_index(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/priority_encoder_reg_pick.sv
// Combinational lowest-set-bit finder over a 2**WIDTH vector.
// found_o is low (and index_o zero) when the vector is empty.
module priority_pick
   import priority_encoder_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic [(2**WIDTH)-1:0] vec_i,
   output logic                  found_o,
   output logic [WIDTH-1:0]      index_o
);

   localparam int unsigned N = 2**WIDTH;

   // Scanning high to low lets the lowest set bit overwrite last.
   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            found_o = 1'b1;
            index_o = WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/priority_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with sticky request capture,
// fixed or round-robin selection, and a valid/ack output handshake.
module priority_encoder_reg
   import priority_encoder_reg_pkg::*;
#(
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned ROUND_ROBIN = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [(2**WIDTH)-1:0] req_in,
   input  logic [(2**WIDTH)-1:0] mask_in,
   input  logic                  clear_in,
   input  logic                  ack_in,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_index,
   output logic [(2**WIDTH)-1:0] out_onehot,
   output logic                  pending_any
);

   localparam int unsigned N    = 2**WIDTH;
   localparam int unsigned IdxW = clog2_index(N);
   localparam prio_mode_e  Mode = (ROUND_ROBIN != 0) ? PRIO_ROUND_ROBIN : PRIO_FIXED;

   logic [N-1:0]    pending_q, pending_d;
   logic [N-1:0]    onehot_q, onehot_d;
   logic            valid_q, valid_d;
   logic [IdxW-1:0] index_q, index_d;
   logic [IdxW-1:0] rr_last_q, rr_last_d;

   logic            ack_acc;
   logic            load;
   logic [N-1:0]    clr_bit;
   logic [N-1:0]    elig;
   logic [IdxW-1:0] ptr;
   logic [IdxW-1:0] shift;
   logic [2*N-1:0]  elig_dbl;
   logic [N-1:0]    elig_rot;
   logic            pick_found;
   logic [IdxW-1:0] pick_idx;
   logic [IdxW-1:0] winner;

   always_comb begin
      ack_acc  = valid_q & ack_in;
      clr_bit  = ack_acc ? onehot_q : '0;
      elig     = pending_q & ~mask_in & ~clr_bit;
      // On an accepted ack the pointer is already moving to out_index, so the
      // same-cycle search starts after the line being retired.
      ptr      = ack_acc ? index_q : rr_last_q;
      shift    = (Mode == PRIO_ROUND_ROBIN) ? ptr + IdxW'(1) : '0;
      elig_dbl = {elig, elig} >> shift;
      elig_rot = elig_dbl[N-1:0];
      winner   = pick_idx + shift;
   end

   priority_pick #(
      .WIDTH (IdxW)
   ) u_pick (
      .vec_i   (elig_rot),
      .found_o (pick_found),
      .index_o (pick_idx)
   );

   always_comb begin
      load      = ~valid_q | ack_in;
      pending_d = (pending_q & ~clr_bit) | req_in;
      valid_d   = valid_q;
      index_d   = index_q;
      onehot_d  = onehot_q;
      rr_last_d = rr_last_q;
      if (clear_in) begin
         pending_d = '0;
         valid_d   = 1'b0;
         onehot_d  = '0;
      end else begin
         if (load) begin
            valid_d  = pick_found;
            onehot_d = '0;
            if (pick_found) begin
               index_d          = winner;
               onehot_d[winner] = 1'b1;
            end
         end
         if (ack_acc && (Mode == PRIO_ROUND_ROBIN)) begin
            rr_last_d = index_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         onehot_q  <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         rr_last_q <= '1;
      end else begin
         pending_q <= pending_d;
         onehot_q  <= onehot_d;
         valid_q   <= valid_d;
         index_q   <= index_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_index   = index_q;
   assign out_onehot  = onehot_q;
   assign pending_any = |pending_q;

endmodule

// File: tb/tb_priority_encoder_reg.sv
// Randomised and directed bench for priority_encoder_reg: fixed and round-robin
// 8-line instances plus a 2-line round-robin instance, all against a scan model.
module tb_priority_encoder_reg;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_in = '0;
   logic [7:0] mask_in = '0;
   logic       clear_in = 1'b0;
   logic       ack_in = 1'b0;

   logic       v_f, pa_f, v_r, pa_r, v_w, pa_w;
   logic [2:0] idx_f, idx_r;
   logic [0:0] idx_w;
   logic [7:0] oh_f, oh_r;
   logic [1:0] oh_w;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   priority_encoder_reg #(.WIDTH(3), .ROUND_ROBIN(0)) dut_fix (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_in(mask_in), .clear_in(clear_in),
      .ack_in(ack_in), .out_valid(v_f), .out_index(idx_f), .out_onehot(oh_f),
      .pending_any(pa_f)
   );

   priority_encoder_reg #(.WIDTH(3), .ROUND_ROBIN(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_in(mask_in), .clear_in(clear_in),
      .ack_in(ack_in), .out_valid(v_r), .out_index(idx_r), .out_onehot(oh_r),
      .pending_any(pa_r)
   );

   priority_encoder_reg #(.WIDTH(1), .ROUND_ROBIN(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .req_in(req_in[1:0]), .mask_in(mask_in[1:0]),
      .clear_in(clear_in), .ack_in(ack_in), .out_valid(v_w), .out_index(idx_w),
      .out_onehot(oh_w), .pending_any(pa_w)
   );

   // Model state per instance: 0 = fixed/8, 1 = rr/8, 2 = rr/2.
   logic [7:0] m_pend [3];
   bit         m_valid [3];
   int         m_idx [3];
   int         m_last [3];
   int         m_n [3] = '{8, 8, 2};
   bit         m_rr [3] = '{1'b0, 1'b1, 1'b1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_pend[k]  = '0;
         m_valid[k] = 1'b0;
         m_idx[k]   = 0;
         m_last[k]  = m_n[k] - 1;
      end
   endtask

   task automatic model_step();
      logic [7:0] lm, r, mk, np, el;
      bit acked, found;
      int n, start, win, old_idx, b;
      for (int k = 0; k < 3; k++) begin
         n  = m_n[k];
         lm = (n == 8) ? 8'hFF : 8'h03;
         r  = req_in & lm;
         mk = mask_in & lm;
         if (clear_in) begin
            m_pend[k]  = '0;
            m_valid[k] = 1'b0;
         end else begin
            acked   = m_valid[k] && ack_in;
            old_idx = m_idx[k];
            np      = m_pend[k];
            if (acked) np[old_idx] = 1'b0;
            np = np | r;
            if (!m_valid[k] || ack_in) begin
               el = m_pend[k] & ~mk;
               if (acked) el[old_idx] = 1'b0;
               start = m_rr[k] ? (((acked ? old_idx : m_last[k]) + 1) % n) : 0;
               found = 1'b0;
               win   = 0;
               for (int j = 0; j < n; j++) begin
                  b = (start + j) % n;
                  if (!found && el[b]) begin
                     found = 1'b1;
                     win   = b;
                  end
               end
               m_valid[k] = found;
               if (found) m_idx[k] = win;
            end
            if (acked && m_rr[k]) m_last[k] = old_idx;
            m_pend[k] = np;
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] gv [3];
      logic [31:0] gi [3];
      logic [31:0] go [3];
      logic [31:0] gp [3];
      logic [31:0] eoh;
      gv[0] = 32'(v_f);  gi[0] = 32'(idx_f); go[0] = 32'(oh_f); gp[0] = 32'(pa_f);
      gv[1] = 32'(v_r);  gi[1] = 32'(idx_r); go[1] = 32'(oh_r); gp[1] = 32'(pa_r);
      gv[2] = 32'(v_w);  gi[2] = 32'(idx_w); go[2] = 32'(oh_w); gp[2] = 32'(pa_w);
      for (int k = 0; k < 3; k++) begin
         eoh = m_valid[k] ? (32'd1 << m_idx[k]) : 32'd0;
         check($sformatf("valid%0d", k), gv[k], 32'(m_valid[k]));
         check($sformatf("index%0d", k), gi[k], 32'(m_idx[k]));
         check($sformatf("onehot%0d", k), go[k], eoh);
         check($sformatf("pend_any%0d", k), gp[k], 32'(|m_pend[k]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int rr_exp [6];
      rr_exp = '{0, 1, 7, 0, 1, 7};
      model_reset();
      #12;
      rst_n = 1'b1;
      compare_all();
      repeat (10) cycle();

      // Fixed-priority pulse: 2, 5, 7, then empty.
      req_in = 8'b1010_0100;
      cycle();
      req_in = '0;
      cycle();
      check("pulse_valid", 32'(v_f), 32'd1);
      check("pulse_idx2", 32'(idx_f), 32'd2);
      ack_in = 1'b1;
      cycle();
      check("pulse_idx5", 32'(idx_f), 32'd5);
      cycle();
      check("pulse_idx7", 32'(idx_f), 32'd7);
      cycle();
      check("pulse_empty", 32'(v_f), 32'd0);
      ack_in = 1'b0;
      cycle();

      // Round-robin wrap with held requests.
      req_in = 8'b1000_0011;
      ack_in = 1'b1;
      cycle();
      for (int i = 0; i < 6; i++) begin
         cycle();
         check($sformatf("rr_seq%0d", i), 32'(idx_r), 32'(rr_exp[i]));
      end
      req_in = '0;
      ack_in = 1'b0;
      clear_in = 1'b1;
      cycle();
      clear_in = 1'b0;

      // Clear beats a same-cycle request.
      req_in = 8'hFF;
      cycle();
      req_in = '0;
      cycle();
      check("pre_clear_valid", 32'(v_f), 32'd1);
      clear_in = 1'b1;
      req_in = 8'h01;
      cycle();
      check("clear_pend", 32'(pa_f), 32'd0);
      check("clear_valid", 32'(v_f), 32'd0);
      clear_in = 1'b0;
      req_in = '0;
      cycle();

      // Mask and hold.
      req_in = 8'b0000_0110;
      mask_in = 8'b0000_0010;
      cycle();
      req_in = '0;
      cycle();
      check("mask_idx2", 32'(idx_f), 32'd2);
      mask_in = 8'b0000_0100;
      cycle();
      cycle();
      check("mask_hold", 32'(idx_f), 32'd2);
      ack_in = 1'b1;
      cycle();
      check("mask_after_ack", 32'(idx_f), 32'd1);
      mask_in = '0;
      cycle();
      ack_in = 1'b0;
      cycle();

      // Ack and re-request of the same line in one cycle.
      req_in = 8'b0101_0000;
      cycle();
      req_in = '0;
      cycle();
      check("simul_idx4", 32'(idx_f), 32'd4);
      ack_in = 1'b1;
      req_in = 8'b0001_0000;
      cycle();
      check("simul_not4", 32'(idx_f), 32'd6);
      req_in = '0;
      cycle();
      check("simul_later4", 32'(idx_f), 32'd4);
      cycle();
      ack_in = 1'b0;
      cycle();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         req_in   = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
         mask_in  = 8'($urandom & $urandom);
         ack_in   = 1'($urandom % 2);
         clear_in = ($urandom % 40 == 0);
         cycle();
      end
      clear_in = 1'b0;
      mask_in = '0;
      ack_in = 1'b0;

      // Asynchronous reset while outputs are valid.
      req_in = 8'hFF;
      cycle();
      req_in = '0;
      cycle();
      check("pre_rst_valid", 32'(v_r), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
